// File: rtl/coder_onehot_seq.sv
// Registered IW -> 2**IW one-hot decoder with valid/ready input.
// Modes: direct (latched decode), pulse (one-hot for a dwell, then cleared)
// and scan (one-hot walks 0..bound, each index held for the dwell).
module coder_onehot_seq #(
  parameter int IW      = 4,
  parameter int DWELL_W = 8,
  parameter int ACT_LOW = 0,
  localparam int OW     = 1 << IW
) (
  input  logic               i_clk,
  input  logic               i_rst,
  input  logic               i_en,
  input  logic [1:0]         i_mode,
  input  logic [DWELL_W-1:0] i_dwell,
  input  logic [IW-1:0]      i_inp,
  input  logic               i_inp_vld,
  output logic               o_inp_rdy,
  output logic [OW-1:0]      o_res,
  output logic [IW-1:0]      o_idx,
  output logic               o_res_vld
);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_HOLD  = 2'd1;
  localparam logic [1:0] S_PULSE = 2'd2;
  localparam logic [1:0] S_SCAN  = 2'd3;

  localparam logic [1:0] M_DIR = 2'b00;
  localparam logic [1:0] M_PUL = 2'b01;
  localparam logic [1:0] M_SCN = 2'b10;

  localparam logic [OW-1:0] INACT = (ACT_LOW != 0) ? {OW{1'b1}} : {OW{1'b0}};

  logic [1:0]         r_state, r_mode;
  logic [IW-1:0]      r_idx, r_bound;
  logic [DWELL_W-1:0] r_cnt;
  logic               r_vld, r_live, r_abort;
  logic [OW-1:0]      r_res;

  logic [1:0]         w_state_n, w_mode_n, w_mode_req;
  logic [IW-1:0]      w_idx_n, w_bound_n, w_bound_eff;
  logic [DWELL_W-1:0] w_cnt_n, w_dwell_m1;
  logic               w_vld_n, w_abort_n, w_mismatch, w_rdy, w_xfer;
  logic [OW-1:0]      w_hot, w_res_n;

  // Reserved mode 11 is folded onto direct so it never looks like a mode change.
  assign w_mode_req = (i_mode == 2'b11) ? M_DIR : i_mode;
  assign w_mismatch = (r_state != S_IDLE) && (w_mode_req != r_mode);
  // r_live keeps ready low for the first cycle out of reset; r_abort for the
  // cycle after a mode-change abort.
  assign w_rdy      = i_en && !i_rst && r_live && !r_abort && !w_mismatch &&
                      (r_state != S_PULSE);
  assign w_xfer     = w_rdy && i_inp_vld;
  // Dwell counts down to zero, so load D-1 with DWELL=0 treated as 1.
  assign w_dwell_m1 = (i_dwell == '0) ? '0 : i_dwell - 1'b1;
  // A bound written in the same cycle as a scan step takes effect for that step.
  assign w_bound_eff = w_xfer ? i_inp : r_bound;

  // Next-state, index, dwell and bound computation.
  always_comb begin
    w_state_n = r_state;
    w_mode_n  = r_mode;
    w_idx_n   = r_idx;
    w_vld_n   = r_vld;
    w_cnt_n   = r_cnt;
    w_bound_n = r_bound;
    w_abort_n = 1'b0;
    if (w_mismatch) begin
      w_state_n = S_IDLE;
      w_idx_n   = '0;
      w_vld_n   = 1'b0;
      w_cnt_n   = '0;
      w_abort_n = 1'b1;
    end else begin
      case (r_state)
        S_IDLE, S_HOLD: begin
          if (w_xfer) begin
            w_mode_n = w_mode_req;
            w_vld_n  = 1'b1;
            case (w_mode_req)
              M_PUL: begin
                w_state_n = S_PULSE;
                w_idx_n   = i_inp;
                w_cnt_n   = w_dwell_m1;
              end
              M_SCN: begin
                w_state_n = S_SCAN;
                w_bound_n = i_inp;
                w_idx_n   = '0;
                w_cnt_n   = w_dwell_m1;
              end
              default: begin
                w_state_n = S_HOLD;
                w_idx_n   = i_inp;
              end
            endcase
          end
        end
        S_PULSE: begin
          if (r_cnt == '0) begin
            w_state_n = S_IDLE;
            w_idx_n   = '0;
            w_vld_n   = 1'b0;
          end else begin
            w_cnt_n = r_cnt - 1'b1;
          end
        end
        default: begin  // S_SCAN
          if (w_xfer) w_bound_n = i_inp;
          if (r_cnt == '0) begin
            w_idx_n = (r_idx >= w_bound_eff) ? '0 : r_idx + 1'b1;
            w_cnt_n = w_dwell_m1;
          end else begin
            w_cnt_n = r_cnt - 1'b1;
          end
        end
      endcase
    end
  end

  // Output code for the next cycle, polarity applied.
  always_comb begin
    w_hot   = {{(OW-1){1'b0}}, 1'b1} << w_idx_n;
    w_res_n = w_vld_n ? w_hot : '0;
    if (ACT_LOW != 0) w_res_n = ~w_res_n;
  end

  // State register; EN=0 freezes everything including the dwell count.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state <= S_IDLE;
      r_mode  <= M_DIR;
      r_idx   <= '0;
      r_bound <= '0;
      r_cnt   <= '0;
      r_vld   <= 1'b0;
      r_live  <= 1'b0;
      r_abort <= 1'b0;
      r_res   <= INACT;
    end else if (i_en) begin
      r_state <= w_state_n;
      r_mode  <= w_mode_n;
      r_idx   <= w_idx_n;
      r_bound <= w_bound_n;
      r_cnt   <= w_cnt_n;
      r_vld   <= w_vld_n;
      r_live  <= 1'b1;
      r_abort <= w_abort_n;
      r_res   <= w_res_n;
    end
  end

  assign o_inp_rdy = w_rdy;
  assign o_res     = r_res;
  assign o_idx     = r_idx;
  assign o_res_vld = r_vld;

endmodule

// File: tb/tb_coder_onehot_seq.sv
// Directed bench for coder_onehot_seq: default instance (IW=4, active-high)
// and a small active-low instance (IW=3, ACT_LOW=1).
module tb_coder_onehot_seq;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int npass = 0;
  int ntot  = 0;

  // Instance A: IW=4, active-high
  logic        a_rst, a_en, a_vld, a_rdy, a_rvld;
  logic [1:0]  a_mode;
  logic [7:0]  a_dwell;
  logic [3:0]  a_inp, a_idx;
  logic [15:0] a_res;

  coder_onehot_seq #(.IW(4), .DWELL_W(8), .ACT_LOW(0)) u_a (
    .i_clk(clk), .i_rst(a_rst), .i_en(a_en), .i_mode(a_mode), .i_dwell(a_dwell),
    .i_inp(a_inp), .i_inp_vld(a_vld), .o_inp_rdy(a_rdy), .o_res(a_res),
    .o_idx(a_idx), .o_res_vld(a_rvld)
  );

  // Instance B: IW=3, active-low
  logic        b_rst, b_en, b_vld, b_rdy, b_rvld;
  logic [1:0]  b_mode;
  logic [7:0]  b_dwell;
  logic [2:0]  b_inp, b_idx;
  logic [7:0]  b_res;

  coder_onehot_seq #(.IW(3), .DWELL_W(8), .ACT_LOW(1)) u_b (
    .i_clk(clk), .i_rst(b_rst), .i_en(b_en), .i_mode(b_mode), .i_dwell(b_dwell),
    .i_inp(b_inp), .i_inp_vld(b_vld), .o_inp_rdy(b_rdy), .o_res(b_res),
    .o_idx(b_idx), .o_res_vld(b_rvld)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    ntot++;
    assert (obs === exp) npass++;
    else $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
  endtask

  // Scan-phase check of instance A: active, index e, one-hot of e.
  task automatic scan_chk(input string tag, input int e);
    logic [15:0] h;
    h = 16'h0001 << e;
    chk({tag, "_idx"}, 32'(a_idx), 32'(e));
    chk({tag, "_res"}, 32'(a_res), 32'(h));
    chk({tag, "_vld"}, 32'(a_rvld), 32'd1);
  endtask

  initial begin
    int seq1[14];
    a_rst = 1; a_en = 1; a_mode = 2'b00; a_dwell = 0; a_inp = 0; a_vld = 0;
    b_rst = 1; b_en = 1; b_mode = 2'b00; b_dwell = 0; b_inp = 0; b_vld = 0;

    // Reset held for two cycles
    tick(); tick();
    chk("rst_res", 32'(a_res), 32'h0000);
    chk("rst_idx", 32'(a_idx), 32'd0);
    chk("rst_vld", 32'(a_rvld), 32'd0);
    chk("rst_rdy", 32'(a_rdy), 32'd0);
    chk("b_rst_res", 32'(b_res), 32'h00FF);
    a_rst = 0; #1;
    chk("rdy_first_cycle", 32'(a_rdy), 32'd0);
    tick();
    chk("rdy_after_rst", 32'(a_rdy), 32'd1);

    // Direct
    a_mode = 2'b00; a_inp = 4'hA; a_vld = 1;
    tick(); a_vld = 0;
    chk("dir_A_res", 32'(a_res), 32'h0400);
    chk("dir_A_idx", 32'(a_idx), 32'hA);
    chk("dir_A_vld", 32'(a_rvld), 32'd1);
    tick();
    chk("dir_A_hold", 32'(a_res), 32'h0400);
    a_inp = 4'hF; a_vld = 1;
    tick(); a_vld = 0;
    chk("dir_F_res", 32'(a_res), 32'h8000);

    // Switching to pulse while holding aborts first
    a_mode = 2'b01; a_dwell = 8'd3; a_inp = 4'd5;
    tick();
    chk("ab_dir_res", 32'(a_res), 32'h0000);
    chk("ab_dir_rdy", 32'(a_rdy), 32'd0);
    tick();
    chk("idle_rdy", 32'(a_rdy), 32'd1);

    // Pulse, DWELL=3
    a_vld = 1;
    tick(); a_vld = 0; a_dwell = 8'd9;  // ignored after transfer
    for (int i = 0; i < 3; i++) begin
      chk("pul3_res", 32'(a_res), 32'h0020);
      chk("pul3_rdy", 32'(a_rdy), 32'd0);
      tick();
    end
    chk("pul3_end_res", 32'(a_res), 32'h0000);
    chk("pul3_end_vld", 32'(a_rvld), 32'd0);
    chk("pul3_end_rdy", 32'(a_rdy), 32'd1);

    // Pulse, DWELL=0 -> one cycle
    a_dwell = 8'd0; a_inp = 4'd7; a_vld = 1;
    tick(); a_vld = 0;
    chk("pul0_res", 32'(a_res), 32'h0080);
    tick();
    chk("pul0_end_res", 32'(a_res), 32'h0000);

    // Scan, DWELL=2, bound 3 (from IDLE, no abort)
    a_mode = 2'b10; a_dwell = 8'd2; a_inp = 4'd3; a_vld = 1;
    tick(); a_vld = 0;
    seq1 = '{0, 0, 1, 1, 2, 2, 3, 3, 0, 0, 1, 1, 2, 2};
    for (int i = 0; i < 14; i++) begin
      scan_chk("scan_b3", seq1[i]);
      tick();
    end
    // First cycle of idx 3: raise bound to 15
    scan_chk("scan_raise", 3);
    a_inp = 4'd15; a_vld = 1;
    chk("scan_rdy", 32'(a_rdy), 32'd1);
    tick(); a_vld = 0;
    scan_chk("scan_raise", 3);
    tick();
    scan_chk("scan_to4", 4);
    tick();
    scan_chk("scan_4b", 4);
    tick();
    scan_chk("scan_5a", 5);

    // Freeze for 5 cycles in the first cycle of idx 5
    a_en = 0;
    for (int i = 0; i < 5; i++) begin
      tick();
      scan_chk("frz", 5);
      chk("frz_rdy", 32'(a_rdy), 32'd0);
    end
    a_en = 1;
    tick();
    scan_chk("resume_5b", 5);
    for (int e = 6; e <= 9; e++) begin
      tick(); scan_chk("scan_up", e);
      if (e != 9) begin
        tick(); scan_chk("scan_up", e);
      end
    end
    // First cycle of idx 9: shrink bound to 2 -> next step wraps to 0
    a_inp = 4'd2; a_vld = 1;
    tick(); a_vld = 0;
    scan_chk("shrink_9", 9);
    tick();
    scan_chk("shrink_wrap", 0);

    // Mode change mid-scan aborts
    a_mode = 2'b00; a_inp = 4'd1; a_vld = 1; #1;
    chk("ab_scan_rdy_now", 32'(a_rdy), 32'd0);
    tick(); a_vld = 0;
    chk("ab_scan_res", 32'(a_res), 32'h0000);
    chk("ab_scan_vld", 32'(a_rvld), 32'd0);
    chk("ab_scan_idx", 32'(a_idx), 32'd0);
    chk("ab_scan_rdy", 32'(a_rdy), 32'd0);
    tick();
    chk("ab_scan_rdy_back", 32'(a_rdy), 32'd1);

    // Active-low instance
    b_rst = 0;
    tick(); tick();
    chk("b_idle_res", 32'(b_res), 32'h00FF);
    b_mode = 2'b00; b_inp = 3'd2; b_vld = 1;
    tick(); b_vld = 0;
    chk("b_dir_res", 32'(b_res), 32'h00FB);
    chk("b_dir_idx", 32'(b_idx), 32'd2);
    b_mode = 2'b01; b_dwell = 8'd5; b_inp = 3'd6;
    tick(); tick();
    b_vld = 1;
    tick(); b_vld = 0;
    chk("b_pul_res", 32'(b_res), 32'h00BF);
    tick();
    b_rst = 1;
    tick();
    chk("b_rst_mid_res", 32'(b_res), 32'h00FF);
    chk("b_rst_mid_vld", 32'(b_rvld), 32'd0);
    chk("b_rst_mid_idx", 32'(b_idx), 32'd0);

    $display("%0d/%0d checks passed", npass, ntot);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end

endmodule
